// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg
//   Shared constants for the pipeline skid stage: default bus widths,
//   bubble encodings, and the global hold-bus levels.
package pipe_skid_stage_pkg;

  localparam int INST_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int INT_W_DEF  = 8;
  localparam int HOLD_W_DEF = 3;

  // addi x0,x0,0
  localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [INT_W_DEF-1:0]  INT_NONE_DEF = 8'h00;

  // Hold bus levels; a stage stalls when the bus is at or above its level.
  typedef enum logic [HOLD_W_DEF-1:0] {
    Hold_None = 3'd0,
    Hold_Pc   = 3'd1,
    Hold_If   = 3'd2,
    Hold_Id   = 3'd3
  } hold_level_e;

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_skid_stage_entry_reg.sv
// pipe_entry_reg
//   One valid+payload register. Clear (reset or flush) empties the entry and
//   loads CLR_VAL; load captures a payload and marks it valid; drop only
//   invalidates, leaving the payload bits untouched.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_clear          synchronous clear (flush)
//   i_load           capture i_data, set valid
//   i_drop           clear valid, keep data
//   i_data           payload in
//   o_valid, o_data  registered entry
module pipe_entry_reg
  import pipe_skid_stage_pkg::*;
#(
  parameter int             W       = 8,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_drop,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= CLR_VAL;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Valid/ready pipeline register with a 2-entry skid buffer carrying
//   {inst, inst_addr, int_flag}. Honors the global hold bus (level compare)
//   and a flush that empties the stage. All outputs come from registers
//   except the bubble substitution on main_valid and in_ready_o.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid_i / in_ready_o        upstream handshake
//   inst_i, inst_addr_i, int_flag_i upstream payload
//   hold_flag_i                    global hold level
//   flush_i                        discard everything held
//   out_valid_o / out_ready_i      downstream handshake
//   inst_o, inst_addr_o, int_flag_o head payload (bubble when empty)
//   occupancy_o                    entries held, 0..2
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                  INST_W     = INST_W_DEF,
  parameter int                  ADDR_W     = ADDR_W_DEF,
  parameter int                  INT_W      = INT_W_DEF,
  parameter int                  HOLD_W     = HOLD_W_DEF,
  parameter logic [HOLD_W-1:0]   HOLD_LEVEL = HOLD_W'(Hold_Pc),
  parameter logic [INST_W-1:0]   NOP_INST   = NOP_INST_DEF,
  parameter logic [INT_W-1:0]    INT_NONE   = INT_NONE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o,
  output logic [1:0]        occupancy_o
);

  localparam int PAY_W = INST_W + ADDR_W + INT_W;
  localparam logic [PAY_W-1:0] BUBBLE = {NOP_INST, {ADDR_W{1'b0}}, INT_NONE};

  logic             w_hold_en;
  logic             w_accept;
  logic             w_pop;
  logic             w_main_valid;
  logic             w_skid_valid;
  logic [PAY_W-1:0] w_main_data;
  logic [PAY_W-1:0] w_skid_data;
  logic [PAY_W-1:0] w_in_data;
  logic [PAY_W-1:0] w_main_next;
  logic             w_main_load;
  logic             w_main_drop;
  logic             w_skid_load;
  logic             w_skid_drop;

  assign w_hold_en  = (hold_flag_i >= HOLD_LEVEL);
  assign in_ready_o = !w_skid_valid && !w_hold_en && !rst;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_pop      = w_main_valid && out_ready_i && !w_hold_en;
  assign w_in_data  = {inst_i, inst_addr_i, int_flag_i};

  // Main refills from skid first so the older entry is never bypassed.
  // Accept into main happens when main is empty or is being popped; a
  // full stage cannot accept because in_ready_o is low.
  assign w_main_next = w_skid_valid ? w_skid_data : w_in_data;
  assign w_main_load = (w_skid_valid && w_pop) ||
                       (w_accept && (!w_main_valid || w_pop));
  assign w_main_drop = w_pop && !w_accept && !w_skid_valid;

  assign w_skid_load = w_accept && w_main_valid && !w_pop;
  assign w_skid_drop = w_skid_valid && w_pop;

  pipe_entry_reg #(
    .W       (PAY_W),
    .CLR_VAL (BUBBLE)
  ) u_main (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (flush_i),
    .i_load  (w_main_load),
    .i_drop  (w_main_drop),
    .i_data  (w_main_next),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  pipe_entry_reg #(
    .W       (PAY_W),
    .CLR_VAL (BUBBLE)
  ) u_skid (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (flush_i),
    .i_load  (w_skid_load),
    .i_drop  (w_skid_drop),
    .i_data  (w_in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign out_valid_o = w_main_valid;
  assign inst_o      = w_main_valid ? w_main_data[PAY_W-1 -: INST_W]        : NOP_INST;
  assign inst_addr_o = w_main_valid ? w_main_data[ADDR_W+INT_W-1 -: ADDR_W] : '0;
  assign int_flag_o  = w_main_valid ? w_main_data[INT_W-1:0]                : INT_NONE;
  assign occupancy_o = occ_count(w_main_valid, w_skid_valid);

  // Skid only ever fills behind a valid head.
  a_no_orphan_skid : assert property (@(posedge clk) disable iff (rst)
    !(w_skid_valid && !w_main_valid))
    else $error("skid entry valid while main entry empty");

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [7:0]  int_flag_i;
  logic [2:0]  hold_flag_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [7:0]  int_flag_o;
  logic [1:0]  occupancy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .int_flag_i  (int_flag_i),
    .hold_flag_i (hold_flag_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .int_flag_o  (int_flag_o),
    .occupancy_o (occupancy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                       input logic [7:0] intf);
    in_valid_i  = v;
    inst_i      = inst;
    inst_addr_i = addr;
    int_flag_i  = intf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h5555_5555, 32'h40, 8'h7);
    out_ready_i = 1'b1;
    hold_flag_i = 3'd0;
    flush_i     = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc%0d: got %b want 0", c, out_valid_o); end
      n_tests++; if (inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst cyc%0d: got %h want 00000013", c, inst_o); end
      n_tests++; if (inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr cyc%0d: got %h want 0", c, inst_addr_o); end
      n_tests++; if (int_flag_o !== 8'h00) begin n_fail++; $display("FAIL reset_int cyc%0d: got %h want 00", c, int_flag_o); end
      n_tests++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready cyc%0d: got %b want 0", c, in_ready_o); end
      n_tests++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL reset_occ cyc%0d: got %0d want 0", c, occupancy_o); end
    end
    rst = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 32'h100, 8'h00);
    #1;
    n_tests++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", in_ready_o); end
    tick();
    n_tests++; if (out_valid_o !== 1'b1 || inst_o !== 32'hAAAA_0001) begin n_fail++; $display("FAIL first_accept: got v=%b inst=%h want v=1 inst=aaaa0001", out_valid_o, inst_o); end
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    tick();
    n_tests++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL drain_after_reset: got occ=%0d want 0", occupancy_o); end
  endtask

  task automatic test_streaming();
    out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h1000_0000 + k, 32'(4 * k), 8'h00);
      tick();
      n_tests++;
      if (out_valid_o !== 1'b1 || inst_o !== 32'h1000_0000 + k || inst_addr_o !== 32'(4 * k) || occupancy_o !== 2'd1) begin
        n_fail++;
        $display("FAIL stream k=%0d: got v=%b inst=%h addr=%h occ=%0d want v=1 inst=%h addr=%h occ=1",
                 k, out_valid_o, inst_o, inst_addr_o, occupancy_o, 32'h1000_0000 + k, 4 * k);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    tick();
    n_tests++; if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got occ=%0d v=%b want 0 0", occupancy_o, out_valid_o); end
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h0000_000A, 32'h10, 8'h00);
    tick();
    n_tests++; if (occupancy_o !== 2'd1 || inst_o !== 32'hA) begin n_fail++; $display("FAIL bp_A: got occ=%0d inst=%h want 1 0000000a", occupancy_o, inst_o); end
    drive(1'b1, 32'h0000_000B, 32'h14, 8'h00);
    tick();
    n_tests++; if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full: got occ=%0d rdy=%b want 2 0", occupancy_o, in_ready_o); end
    drive(1'b1, 32'h0000_000C, 32'h18, 8'h00);
    tick();
    n_tests++; if (occupancy_o !== 2'd2 || inst_o !== 32'hA || inst_addr_o !== 32'h10) begin n_fail++; $display("FAIL bp_stall: got occ=%0d inst=%h addr=%h want 2 0000000a 00000010", occupancy_o, inst_o, inst_addr_o); end
    out_ready_i = 1'b1;
    tick();
    n_tests++; if (inst_o !== 32'hB || inst_addr_o !== 32'h14 || occupancy_o !== 2'd1) begin n_fail++; $display("FAIL bp_B: got inst=%h addr=%h occ=%0d want 0000000b 00000014 1", inst_o, inst_addr_o, occupancy_o); end
    tick();
    n_tests++; if (inst_o !== 32'hC || inst_addr_o !== 32'h18 || occupancy_o !== 2'd1) begin n_fail++; $display("FAIL bp_C: got inst=%h addr=%h occ=%0d want 0000000c 00000018 1", inst_o, inst_addr_o, occupancy_o); end
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    tick();
    n_tests++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL bp_drain: got occ=%0d want 0", occupancy_o); end
  endtask

  task automatic test_hold();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h0000_0A00, 32'h200, 8'h00);
    tick();
    hold_flag_i = 3'd1;
    out_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0A01, 32'h204, 8'h00);
    #1;
    n_tests++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %b want 0", in_ready_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (out_valid_o !== 1'b1 || inst_o !== 32'h0A00 || occupancy_o !== 2'd1 || in_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_frozen c=%0d: got v=%b inst=%h occ=%0d rdy=%b want 1 00000a00 1 0", c, out_valid_o, inst_o, occupancy_o, in_ready_o);
      end
    end
    hold_flag_i = 3'd0;
    tick();
    n_tests++; if (inst_o !== 32'h0A01 || occupancy_o !== 2'd1) begin n_fail++; $display("FAIL hold_resume: got inst=%h occ=%0d want 00000a01 1", inst_o, occupancy_o); end
    hold_flag_i = 3'd2;
    drive(1'b1, 32'h0000_0A02, 32'h208, 8'h00);
    tick();
    n_tests++; if (inst_o !== 32'h0A01 || occupancy_o !== 2'd1) begin n_fail++; $display("FAIL hold_above_level: got inst=%h occ=%0d want 00000a01 1", inst_o, occupancy_o); end
    hold_flag_i = 3'd0;
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    tick();
    n_tests++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL hold_drain: got occ=%0d want 0", occupancy_o); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h0000_0F00, 32'h300, 8'h01);
    tick();
    drive(1'b1, 32'h0000_0F01, 32'h304, 8'h02);
    tick();
    n_tests++; if (occupancy_o !== 2'd2) begin n_fail++; $display("FAIL flush_fill: got occ=%0d want 2", occupancy_o); end
    flush_i     = 1'b1;
    hold_flag_i = 3'd1;
    drive(1'b1, 32'h0000_0F02, 32'h308, 8'h03);
    tick();
    n_tests++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || inst_o !== 32'h13 || inst_addr_o !== 32'h0 || int_flag_o !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_empty: got occ=%0d v=%b inst=%h addr=%h int=%h want 0 0 00000013 0 00", occupancy_o, out_valid_o, inst_o, inst_addr_o, int_flag_o);
    end
    flush_i     = 1'b0;
    hold_flag_i = 3'd0;
    out_ready_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    tick();
    n_tests++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin n_fail++; $display("FAIL flush_dropped_input: got v=%b occ=%0d want 0 0", out_valid_o, occupancy_o); end
  endtask

  task automatic test_int_flag();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h0000_1111, 32'h20, 8'h00);
    tick();
    drive(1'b1, 32'hDEAD_BEEF, 32'h24, 8'h04);
    tick();
    n_tests++; if (occupancy_o !== 2'd2 || int_flag_o !== 8'h00) begin n_fail++; $display("FAIL int_fill: got occ=%0d int=%h want 2 00", occupancy_o, int_flag_o); end
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    out_ready_i = 1'b1;
    tick();
    n_tests++;
    if (inst_o !== 32'hDEAD_BEEF || inst_addr_o !== 32'h24 || int_flag_o !== 8'h04) begin
      n_fail++;
      $display("FAIL int_carry: got inst=%h addr=%h int=%h want deadbeef 00000024 04", inst_o, inst_addr_o, int_flag_o);
    end
    tick();
    n_tests++; if (occupancy_o !== 2'd0 || int_flag_o !== 8'h00) begin n_fail++; $display("FAIL int_drain: got occ=%0d int=%h want 0 00", occupancy_o, int_flag_o); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_hold();
    test_flush();
    test_int_flag();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
